// File: rtl/qc_shift_scheduler.sv
// Walks a programmable QC-LDPC base-matrix table row-major, issuing shift/column
// commands to a fixed-latency circular shifter and realigning entry tags to its output.
module qc_shift_scheduler #(
    parameter int MAXZ      = 8,
    parameter int MAX_ROWS  = 4,
    parameter int MAX_COLS  = 8,
    parameter int SHIFT_LAT = 4,
    parameter int CREDITS   = 4
) (
    input  logic                          CLK,
    input  logic                          rst_n,
    input  logic                          cfg_we,
    input  logic [$clog2(MAX_ROWS)-1:0]   cfg_row,
    input  logic [$clog2(MAX_COLS)-1:0]   cfg_col,
    input  logic                          cfg_present,
    input  logic [$clog2(MAXZ)-1:0]       cfg_shift,
    input  logic [$clog2(MAX_ROWS):0]     cfg_nrows,
    input  logic [$clog2(MAX_COLS):0]     cfg_ncols,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(MAXZ)-1:0]       sh_shift_val,
    output logic [$clog2(MAX_COLS)-1:0]   sh_col,
    output logic                          sh_issue,
    output logic                          out_valid,
    output logic [$clog2(MAX_ROWS)-1:0]   out_row,
    output logic [$clog2(MAX_COLS)-1:0]   out_col,
    output logic                          out_last,
    input  logic                          ret_credit,
    output logic                          credit_err
);
    localparam int ZW = $clog2(MAXZ);
    localparam int RW = $clog2(MAX_ROWS);
    localparam int CW = $clog2(MAX_COLS);
    localparam int NE = MAX_ROWS * MAX_COLS;
    localparam int IW = $clog2(NE);
    localparam int KW = $clog2(CREDITS + 1);
    // Every delay stage except the output one; the output stage empties on the done edge.
    localparam logic [SHIFT_LAT-1:0] HEAD_MASK = SHIFT_LAT'((64'd1 << (SHIFT_LAT - 1)) - 64'd1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state_reg;
    logic [RW-1:0]   row_reg, issue_row_reg;
    logic [CW-1:0]   col_reg;
    logic [RW:0]     nrows_reg;
    logic [CW:0]     ncols_reg;
    logic            issue_last_reg;
    logic [KW-1:0]   credit_reg;

    logic            present_mem [NE];
    logic [ZW-1:0]   shift_mem   [NE];

    logic [SHIFT_LAT-1:0] dl_valid, dl_last;
    logic [RW-1:0]        dl_row [SHIFT_LAT];
    logic [CW-1:0]        dl_col [SHIFT_LAT];

    logic [IW-1:0]   wr_idx, cur_idx;
    logic            cur_present, issue_now, advance, col_last, at_end, is_last, pending, bad_dims;
    logic [ZW-1:0]   cur_shift;
    logic [NE-1:0]   later_present;

    assign wr_idx      = IW'(cfg_row) * IW'(MAX_COLS) + IW'(cfg_col);
    assign cur_idx     = IW'(row_reg) * IW'(MAX_COLS) + IW'(col_reg);
    assign cur_present = present_mem[cur_idx];
    assign cur_shift   = shift_mem[cur_idx];
    assign issue_now   = (state_reg == RUN) && cur_present && (credit_reg != '0);
    assign advance     = (state_reg == RUN) && (!cur_present || (credit_reg != '0));
    assign col_last    = ({1'b0, col_reg} == ncols_reg - (CW+1)'(1));
    assign at_end      = col_last && ({1'b0, row_reg} == nrows_reg - (RW+1)'(1));
    assign pending     = sh_issue || (|(dl_valid & HEAD_MASK));
    assign bad_dims    = (cfg_nrows == '0) || (cfg_ncols == '0) ||
                         (cfg_nrows > (RW+1)'(MAX_ROWS)) || (cfg_ncols > (CW+1)'(MAX_COLS));

    // Lookahead: an entry is last when no present entry follows it inside the active window.
    genvar gi;
    for (gi = 0; gi < NE; gi++) begin : g_look
        localparam logic [RW:0] ER = (RW+1)'(gi / MAX_COLS);
        localparam logic [CW:0] EC = (CW+1)'(gi % MAX_COLS);
        assign later_present[gi] = present_mem[gi] && (ER < nrows_reg) && (EC < ncols_reg) &&
            ((ER > {1'b0, row_reg}) || ((ER == {1'b0, row_reg}) && (EC > {1'b0, col_reg})));
    end
    assign is_last = ~|later_present;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NE; i++) begin
                present_mem[i] <= 1'b0;
                shift_mem[i]   <= '0;
            end
        end else if (cfg_we && !busy) begin
            present_mem[wr_idx] <= cfg_present;
            shift_mem[wr_idx]   <= cfg_shift;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            row_reg        <= '0;
            col_reg        <= '0;
            nrows_reg      <= '0;
            ncols_reg      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            sh_issue       <= 1'b0;
            sh_shift_val   <= '0;
            sh_col         <= '0;
            issue_row_reg  <= '0;
            issue_last_reg <= 1'b0;
        end else begin
            done     <= 1'b0;
            sh_issue <= issue_now;
            if (issue_now) begin
                sh_shift_val   <= cur_shift;
                sh_col         <= col_reg;
                issue_row_reg  <= row_reg;
                issue_last_reg <= is_last;
            end
            case (state_reg)
                IDLE: if (start) begin
                    nrows_reg <= cfg_nrows;
                    ncols_reg <= cfg_ncols;
                    row_reg   <= '0;
                    col_reg   <= '0;
                    busy      <= 1'b1;
                    state_reg <= bad_dims ? DRAIN : RUN;
                end
                RUN: if (advance) begin
                    if (at_end) begin
                        state_reg <= DRAIN;
                    end else if (col_last) begin
                        col_reg <= '0;
                        row_reg <= row_reg + RW'(1);
                    end else begin
                        col_reg <= col_reg + CW'(1);
                    end
                end
                DRAIN: if (!pending) begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // A return coinciding with an issue cancels out; a return into a full counter is an error.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            credit_reg <= KW'(CREDITS);
            credit_err <= 1'b0;
        end else begin
            case ({issue_now, ret_credit})
                2'b10: credit_reg <= credit_reg - KW'(1);
                2'b01: begin
                    if (credit_reg == KW'(CREDITS)) credit_err <= 1'b1;
                    else                            credit_reg <= credit_reg + KW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            dl_valid <= '0;
            dl_last  <= '0;
            for (int i = 0; i < SHIFT_LAT; i++) begin
                dl_row[i] <= '0;
                dl_col[i] <= '0;
            end
        end else begin
            dl_valid[0] <= sh_issue;
            dl_last[0]  <= sh_issue && issue_last_reg;
            dl_row[0]   <= issue_row_reg;
            dl_col[0]   <= sh_col;
            for (int i = 1; i < SHIFT_LAT; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_last[i]  <= dl_last[i-1];
                dl_row[i]   <= dl_row[i-1];
                dl_col[i]   <= dl_col[i-1];
            end
        end
    end

    assign out_valid = dl_valid[SHIFT_LAT-1];
    assign out_last  = dl_last[SHIFT_LAT-1];
    assign out_row   = dl_row[SHIFT_LAT-1];
    assign out_col   = dl_col[SHIFT_LAT-1];
endmodule

// File: tb/tb_qc_shift_scheduler.sv
// Directed bench for qc_shift_scheduler: issue order, skips, tag latency, credits,
// busy-time protection and asynchronous reset.
module tb_qc_shift_scheduler;
    logic       CLK = 1'b0, rst_n = 1'b0, cfg_we = 1'b0, cfg_present = 1'b0;
    logic       start = 1'b0, ret_credit = 1'b0;
    logic [1:0] cfg_row = '0;
    logic [2:0] cfg_col = '0, cfg_shift = '0, cfg_nrows = '0;
    logic [3:0] cfg_ncols = '0;
    logic       busy, done, sh_issue, out_valid, out_last, credit_err;
    logic [2:0] sh_shift_val, sh_col, out_col;
    logic [1:0] out_row;

    qc_shift_scheduler dut (
        .CLK(CLK), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_col(cfg_col),
        .cfg_present(cfg_present), .cfg_shift(cfg_shift), .cfg_nrows(cfg_nrows),
        .cfg_ncols(cfg_ncols), .start(start), .busy(busy), .done(done),
        .sh_shift_val(sh_shift_val), .sh_col(sh_col), .sh_issue(sh_issue),
        .out_valid(out_valid), .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .ret_credit(ret_credit), .credit_err(credit_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int iss_cyc[$], iss_col[$], iss_shift[$];
    int ov_cyc[$], ov_row[$], ov_col[$], ov_last[$];
    int done_q[$];

    always @(negedge CLK) begin
        if (sh_issue) begin
            iss_cyc.push_back(cyc); iss_col.push_back(int'(sh_col)); iss_shift.push_back(int'(sh_shift_val));
            $display("[%0d] issue col=%0d shift=%0d", cyc, sh_col, sh_shift_val);
        end
        if (out_valid) begin
            ov_cyc.push_back(cyc); ov_row.push_back(int'(out_row));
            ov_col.push_back(int'(out_col)); ov_last.push_back(int'(out_last));
            $display("[%0d] out row=%0d col=%0d last=%0d", cyc, out_row, out_col, out_last);
        end
        if (done) begin
            done_q.push_back(cyc);
            $display("[%0d] done", cyc);
        end
    end

    int passed = 0, failed = 0, total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int r, input int c, input logic p, input int s);
        cfg_we = 1'b1; cfg_row = 2'(r); cfg_col = 3'(c); cfg_present = p; cfg_shift = 3'(s);
        tick(1);
        cfg_we = 1'b0;
    endtask

    task automatic start_pass(input int nr, input int nc, output int s);
        cfg_nrows = 3'(nr); cfg_ncols = 4'(nc); start = 1'b1; s = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic ret_n(input int n);
        ret_credit = 1'b1;
        tick(n);
        ret_credit = 1'b0;
    endtask

    task automatic clear_logs();
        iss_cyc.delete(); iss_col.delete(); iss_shift.delete();
        ov_cyc.delete(); ov_row.delete(); ov_col.delete(); ov_last.delete(); done_q.delete();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_q.size() == 0 && n < 200) begin
            tick(1);
            n++;
        end
        chk({tag, "_done_seen"}, done_q.size() > 0, 1);
        tick(2);
    endtask

    int s, r0;
    int sh1[4] = '{0, 3, 5, 7};
    int t2_row[4] = '{0, 0, 1, 1};
    int t2_col[4] = '{0, 2, 1, 2};
    int t2_sh[4]  = '{0, 5, 2, 6};
    int t2_off[4] = '{2, 4, 6, 7};

    initial begin
        // Reset state
        tick(2);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_issue", sh_issue, 0);
        chk("rst_ovalid", out_valid, 0); chk("rst_cerr", credit_err, 0);
        rst_n = 1'b1;
        tick(2);

        // 1x4 all present, shifts 0,3,5,7
        for (int c = 0; c < 4; c++) wr(0, c, 1'b1, sh1[c]);
        clear_logs();
        start_pass(1, 4, s);
        wait_done("t1");
        chk("t1_iss_n", iss_cyc.size(), 4);
        chk("t1_ov_n", ov_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_iss_cyc%0d", i), iss_cyc[i], s + 2 + i);
            chk($sformatf("t1_iss_col%0d", i), iss_col[i], i);
            chk($sformatf("t1_iss_sh%0d", i), iss_shift[i], sh1[i]);
            chk($sformatf("t1_ov_cyc%0d", i), ov_cyc[i], s + 6 + i);
            chk($sformatf("t1_ov_col%0d", i), ov_col[i], i);
            chk($sformatf("t1_ov_last%0d", i), ov_last[i], (i == 3) ? 1 : 0);
        end
        chk("t1_done_cyc", done_q[0], s + 10);
        chk("t1_busy_after", busy, 0);
        ret_n(4);

        // 2x3 with (0,1),(1,0) absent; last write coincides with start
        wr(0, 1, 1'b0, 0);
        wr(1, 1, 1'b1, 2);
        clear_logs();
        cfg_we = 1'b1; cfg_row = 2'd1; cfg_col = 3'd2; cfg_present = 1'b1; cfg_shift = 3'd6;
        start_pass(2, 3, s);
        cfg_we = 1'b0;
        wait_done("t2");
        chk("t2_iss_n", iss_cyc.size(), 4);
        chk("t2_ov_n", ov_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_iss_cyc%0d", i), iss_cyc[i], s + t2_off[i]);
            chk($sformatf("t2_iss_col%0d", i), iss_col[i], t2_col[i]);
            chk($sformatf("t2_iss_sh%0d", i), iss_shift[i], t2_sh[i]);
            chk($sformatf("t2_ov_row%0d", i), ov_row[i], t2_row[i]);
            chk($sformatf("t2_ov_col%0d", i), ov_col[i], t2_col[i]);
            chk($sformatf("t2_ov_last%0d", i), ov_last[i], (i == 3) ? 1 : 0);
        end
        ret_n(4);

        // 1x8 all present, credit stall and release
        for (int c = 0; c < 8; c++) wr(0, c, 1'b1, c);
        clear_logs();
        start_pass(1, 8, s);
        tick(10);
        chk("t3_stall_n", iss_cyc.size(), 4);
        chk("t3_stall_busy", busy, 1);
        ret_n(1);
        tick(6);
        chk("t3_one_more_n", iss_cyc.size(), 5);
        chk("t3_one_more_col", iss_col[4], 4);
        ret_n(3);
        wait_done("t3");
        chk("t3_iss_n", iss_cyc.size(), 8);
        chk("t3_ov_n", ov_cyc.size(), 8);
        for (int i = 5; i < 8; i++) chk($sformatf("t3_iss_col%0d", i), iss_col[i], i);
        chk("t3_same_cycle_ret", iss_cyc[7] - iss_cyc[5], 2);
        chk("t3_last_col", ov_col[7], 7);
        chk("t3_last_flag", ov_last[7], 1);
        chk("t3_early_last", ov_last[6], 0);

        // Credit overflow is sticky
        ret_n(4);
        chk("t4_cerr_full_ok", credit_err, 0);
        ret_n(1);
        chk("t4_cerr_set", credit_err, 1);
        tick(3);
        chk("t4_cerr_sticky", credit_err, 1);

        // Zero / oversize dimensions
        clear_logs();
        start_pass(1, 0, s);
        wait_done("t5a");
        chk("t5a_iss_n", iss_cyc.size(), 0);
        chk("t5a_done_cyc", done_q[0], s + 2);
        clear_logs();
        start_pass(5, 4, s);
        wait_done("t5b");
        chk("t5b_iss_n", iss_cyc.size(), 0);
        chk("t5b_done_cyc", done_q[0], s + 2);

        // start and cfg_we while busy are ignored
        clear_logs();
        start_pass(1, 4, s);
        cfg_we = 1'b1; cfg_row = 2'd0; cfg_col = 3'd1; cfg_present = 1'b0; cfg_shift = 3'd0;
        start = 1'b1; cfg_ncols = 4'd8;
        tick(1);
        cfg_we = 1'b0; start = 1'b0;
        wait_done("t6");
        tick(10);
        chk("t6_done_n", done_q.size(), 1);
        chk("t6_iss_n", iss_cyc.size(), 4);
        ret_n(4);
        clear_logs();
        start_pass(1, 4, s);
        wait_done("t6b");
        chk("t6b_iss_n", iss_cyc.size(), 4);
        chk("t6b_col1_kept", iss_shift[1], 1);
        ret_n(4);

        // Reset mid-RUN
        clear_logs();
        start_pass(1, 8, s);
        tick(3);
        rst_n = 1'b0;
        #2;
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_issue", sh_issue, 0);
        chk("t7_rst_ovalid", out_valid, 0);
        clear_logs();
        tick(2);
        rst_n = 1'b1;
        tick(10);
        chk("t7_no_done", done_q.size(), 0);
        chk("t7_cerr_clr", credit_err, 0);
        start_pass(1, 8, r0);
        wait_done("t7b");
        chk("t7b_iss_n", iss_cyc.size(), 0);
        chk("t7b_done_cyc", done_q[0], r0 + 10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/qc_shift_scheduler.md
Name: qc_shift_scheduler

Overview:
Sequences the pipelined circular shifter across one QC-LDPC base matrix. It holds a small programmable table of shift values and walks it row-major, one entry per cycle. For each entry it presents the shift value and a column select to the shifter, skipping zero (absent) blocks. It delays the entry tags to line up with the shifter's fixed output latency, and limits in-flight results with a credit counter, because the shifter has no stall input.

Parameters:
MAXZ, 8, lifting size; shifter width; power of two required
MAX_ROWS, 4, base-matrix rows supported
MAX_COLS, 8, base-matrix columns supported
SHIFT_LAT, 4, shifter latency in cycles from shift_val to out_data; must be >= 1
CREDITS, 4, downstream result-buffer slots

Ports:
CLK  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  table write strobe; ignored while busy
cfg_row  in  clog2(MAX_ROWS)  write row
cfg_col  in  clog2(MAX_COLS)  write column
cfg_present  in  1  1 = circulant present, 0 = zero block
cfg_shift  in  clog2(MAXZ)  rotate-right amount
cfg_nrows  in  clog2(MAX_ROWS)+1  active rows; sampled on start
cfg_ncols  in  clog2(MAX_COLS)+1  active columns; sampled on start
start  in  1  single-cycle pulse; begin a pass
busy  out  1  pass in progress, including drain
done  out  1  one-cycle pulse at end of pass
sh_shift_val  out  clog2(MAXZ)  drives shifter shift_val
sh_col  out  clog2(MAX_COLS)  column select for shifter input mux/memory
sh_issue  out  1  entry issued this cycle
out_valid  out  1  shifter out_data valid this cycle
out_row  out  clog2(MAX_ROWS)  row tag aligned to out_valid
out_col  out  clog2(MAX_COLS)  column tag aligned to out_valid
out_last  out  1  final issued entry of the pass, aligned to out_valid
ret_credit  in  1  downstream freed one slot
credit_err  out  1  sticky: credit returned while counter full

Behaviour:
- Reset (asynchronous): all outputs 0, FSM = IDLE, credit count = CREDITS, delay line cleared. The table contents are also cleared, so every entry reads as absent.
- Table: MAX_ROWS x MAX_COLS entries of {present, shift}.
  - cfg_we writes are registered.
  - A write and a start in the same cycle: the write lands first, then the pass starts.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start latches nrows/ncols, row = col = 0, busy = 1, next state RUN.
  - If latched nrows or ncols is 0, or exceeds its MAX, go directly to DRAIN with nothing issued.
- RUN, one table position evaluated per cycle:
  - Entry absent: no issue; advance pointer.
  - Entry present and credits > 0: register sh_issue = 1, sh_shift_val = shift, sh_col = col; decrement credit; advance pointer.
  - Entry present and credits = 0: hold pointer; sh_issue = 0.
  - Pointer advance: col+1; at col = ncols-1, wrap col to 0 and increment row.
  - After position (nrows-1, ncols-1) is handled, go to DRAIN.
  - out_last is tagged on the last issued entry, not on a skipped trailing position.
- sh_shift_val and sh_col hold their last value when sh_issue = 0.
- Delay line: SHIFT_LAT-deep shift register of {valid, row, col, last}, loaded from the issue stage.
  - An issue registered in cycle t produces out_valid with matching tags in cycle t+SHIFT_LAT.
- DRAIN: wait until the delay line holds no valid entry. Then pulse done for one cycle, busy = 0, go to IDLE.
  - With no issues at all, done comes one cycle after entering DRAIN.
- start while busy: ignored.
- Credits:
  - ret_credit and an issue in the same cycle: count unchanged.
  - ret_credit at count = CREDITS: count saturates and credit_err sets. It clears only on reset.
  - The counter is not reloaded between passes.
- Reset mid-pass: immediate return to IDLE. In-flight tags are discarded and no done is generated.

Test Plan:
- Program a 1x4 row, all present, shifts 0,3,5,7; start -> sh_issue high 4 consecutive cycles with shifts 0,3,5,7 and cols 0..3. out_valid follows exactly SHIFT_LAT later with cols 0..3; out_last on col 3; done one cycle after the last out_valid.
- Program 2x3 with (0,1) and (1,0) absent -> exactly 4 issues in order (0,0),(0,2),(1,1),(1,2). Two skip cycles produce no issue, and out_last is on (1,2).
- CREDITS=4, no ret_credit, 1x8 all present -> 4 issues then stall. Pulse ret_credit once -> exactly one further issue (col 4). Return credits until all 8 are issued -> done.
- ret_credit on the same cycle as an issue at count=1 -> count stays 1 and the next entry still issues. ret_credit with count=4 -> credit_err=1 and stays 1.
- Start with cfg_ncols=0 -> no sh_issue, done pulse within 2 cycles. A start pulse during busy, and cfg_we during busy, have no effect (table readback via a second pass is unchanged).
- Assert rst_n low mid-RUN -> busy/out_valid/sh_issue go 0 immediately and no done appears. A new start after release runs the table cleared by reset, so no issues and a done pulse.
